// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen
//   Parametrised VGA timing and test-pattern generator. A free-running
//   pixel/line counter pair (stage 0) drives sync, data-enable and one of four
//   test patterns, all registered together on the pixel strobe (stage 1) so
//   the syncs and pixels reach the pins with identical latency.
//
//   Optional feature macro: VGA_PATTERN_SCROLL_EN
//     defined   - an 8-bit frame counter offsets the checkerboard x position,
//                 so the board scrolls by one pixel per frame.
//     undefined - the checkerboard is static and no frame counter is built.
//
// Ports
//   clk          system clock
//   rst          synchronous active-high reset (priority over pix_ce)
//   pix_ce       pixel strobe; all state advances only when high
//   mode[1:0]    pattern select (0 solid red, 1 bars, 2 checker, 3 border),
//                taken into effect at the frame wrap only
//   R/G/B        colour outputs (RW/GW/BW bits), registered
//   HS/VS        sync outputs, active level HS_POL/VS_POL, registered
//   de           data enable, high for visible pixels, registered
//   hcount       current column (stage 0)
//   vcount       current line (stage 0)
//   frame_start  one-clk pulse while the counters have just wrapped to (0,0)
module vga_pattern_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int RW       = 3,
    parameter int GW       = 3,
    parameter int BW       = 2,
    parameter int CHK_LOG2 = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pix_ce,
    input  logic [1:0]    mode,
    output logic [RW-1:0] R,
    output logic [GW-1:0] G,
    output logic [BW-1:0] B,
    output logic          HS,
    output logic          VS,
    output logic          de,
    output logic [10:0]   hcount,
    output logic [10:0]   vcount,
    output logic          frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
    localparam logic [10:0] H_EDGE   = 11'(H_ACTIVE - 1);
    localparam logic [10:0] V_EDGE   = 11'(V_ACTIVE - 1);
    localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [10:0] BAR_LAST = 11'(H_ACTIVE / 8 - 1);

    logic [10:0]   hcount_r;
    logic [10:0]   vcount_r;
    logic [1:0]    mode_q_r;
    logic          frame_start_r;
    logic [10:0]   bar_px_r;
    logic [2:0]    bar_idx_r;
    logic          h_last_s;
    logic          v_last_s;
    logic          wrap_s;
    logic          visible_s;
    logic          chk_on_s;
    logic          border_s;
    logic          hs_s;
    logic          vs_s;
    logic [RW-1:0] r_s;
    logic [GW-1:0] g_s;
    logic [BW-1:0] b_s;

    assign h_last_s  = (hcount_r == H_LAST);
    assign v_last_s  = (vcount_r == V_LAST);
    assign wrap_s    = pix_ce & h_last_s & v_last_s;
    assign visible_s = (hcount_r < H_ACT) && (vcount_r < V_ACT);
    assign border_s  = (hcount_r == 11'd0) || (hcount_r == H_EDGE) ||
                       (vcount_r == 11'd0) || (vcount_r == V_EDGE);

`ifdef VGA_PATTERN_SCROLL_EN
    localparam int CHK_W = CHK_LOG2 + 1;
    logic [7:0]       frame_cnt_r;
    logic [CHK_W-1:0] chk_x_s;

    // Frame counter: advances once per frame wrap, used only for scrolling.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_r <= 8'd0;
        end else if (wrap_s) begin
            frame_cnt_r <= frame_cnt_r + 8'd1;
        end
    end

    // Only bit CHK_LOG2 of the sum matters, so the sum is kept modulo 2^CHK_W.
    assign chk_x_s  = hcount_r[CHK_W-1:0] + CHK_W'(frame_cnt_r);
    assign chk_on_s = chk_x_s[CHK_LOG2] ^ vcount_r[CHK_LOG2];
`else
    assign chk_on_s = hcount_r[CHK_LOG2] ^ vcount_r[CHK_LOG2];
`endif

    // Stage 0 pixel/line counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            hcount_r <= 11'd0;
            vcount_r <= 11'd0;
        end else if (pix_ce) begin
            if (h_last_s) begin
                hcount_r <= 11'd0;
                if (v_last_s) begin
                    vcount_r <= 11'd0;
                end else begin
                    vcount_r <= vcount_r + 11'd1;
                end
            end else begin
                hcount_r <= hcount_r + 11'd1;
            end
        end
    end

    // Frame-start pulse and pattern register; both act only on the frame wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_start_r <= 1'b0;
            mode_q_r      <= 2'd0;
        end else begin
            frame_start_r <= wrap_s;
            if (wrap_s) begin
                mode_q_r <= mode;
            end
        end
    end

    // Bar tracker: bar_idx_r = hcount/(H_ACTIVE/8) without a divider.
    always_ff @(posedge clk) begin
        if (rst) begin
            bar_px_r  <= 11'd0;
            bar_idx_r <= 3'd0;
        end else if (pix_ce) begin
            if (h_last_s) begin
                bar_px_r  <= 11'd0;
                bar_idx_r <= 3'd0;
            end else if (bar_px_r == BAR_LAST) begin
                bar_px_r  <= 11'd0;
                bar_idx_r <= bar_idx_r + 3'd1;
            end else begin
                bar_px_r <= bar_px_r + 11'd1;
            end
        end
    end

    // Sync decode from the stage 0 counters.
    always_comb begin
        hs_s = ~HS_POL;
        vs_s = ~VS_POL;
        if ((hcount_r >= HS_START) && (hcount_r < HS_END)) begin
            hs_s = HS_POL;
        end else begin
            hs_s = ~HS_POL;
        end
        if ((vcount_r >= VS_START) && (vcount_r < VS_END)) begin
            vs_s = VS_POL;
        end else begin
            vs_s = ~VS_POL;
        end
    end

    // Pattern colour for the current stage 0 position; black outside visible.
    always_comb begin
        r_s = {RW{1'b0}};
        g_s = {GW{1'b0}};
        b_s = {BW{1'b0}};
        if (visible_s) begin
            case (mode_q_r)
                2'd0: begin
                    r_s = {RW{1'b1}};
                end
                2'd1: begin
                    r_s = {RW{bar_idx_r[2]}};
                    g_s = {GW{bar_idx_r[1]}};
                    b_s = {BW{bar_idx_r[0]}};
                end
                2'd2: begin
                    r_s = {RW{chk_on_s}};
                    g_s = {GW{chk_on_s}};
                    b_s = {BW{chk_on_s}};
                end
                2'd3: begin
                    r_s = {RW{border_s}};
                    g_s = {GW{border_s}};
                    b_s = {BW{border_s}};
                end
                default: begin
                    r_s = {RW{1'b0}};
                    g_s = {GW{1'b0}};
                    b_s = {BW{1'b0}};
                end
            endcase
        end else begin
            r_s = {RW{1'b0}};
            g_s = {GW{1'b0}};
            b_s = {BW{1'b0}};
        end
    end

    // Stage 1 output registers: colour, syncs and de share one pipeline step.
    always_ff @(posedge clk) begin
        if (rst) begin
            R  <= {RW{1'b0}};
            G  <= {GW{1'b0}};
            B  <= {BW{1'b0}};
            HS <= ~HS_POL;
            VS <= ~VS_POL;
            de <= 1'b0;
        end else if (pix_ce) begin
            R  <= r_s;
            G  <= g_s;
            B  <= b_s;
            HS <= hs_s;
            VS <= vs_s;
            de <= visible_s;
        end
    end

    assign hcount      = hcount_r;
    assign vcount      = vcount_r;
    assign frame_start = frame_start_r;

endmodule
